// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO on an inferred simple dual-port RAM with occupancy thresholds,
// optional first-word-fall-through output, synchronous flush and sticky error flags.
module sync_fifo_ram #(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned AWIDTH   = 8,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = (1 << AWIDTH) - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int unsigned     DEPTH     = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_CNT    = (AWIDTH + 1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] AE_CNT    = (AWIDTH + 1)'(AE_LEVEL);
    localparam logic [AWIDTH:0] ONE       = (AWIDTH + 1)'(1);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH:0]   wr_ptr_q, rd_ptr_q, count_q;
    logic [DWIDTH-1:0] mid_data_q, rd_data_q;
    logic              mid_valid_q, rd_valid_q, overflow_q, underflow_q;

    logic              full_c, empty_c, wr_acc, rd_acc, ovf_evt, unf_evt;
    logic              ram_rd, out_load;
    logic [AWIDTH:0]   ram_level;

    always_comb begin
        full_c    = (count_q == DEPTH_CNT);
        empty_c   = (FWFT != 0) ? !rd_valid_q : (count_q == '0);
        wr_acc    = wr_en && !full_c && !flush;
        rd_acc    = rd_en && !empty_c && !flush;
        ovf_evt   = wr_en && full_c && !flush;
        unf_evt   = rd_en && empty_c && !flush;
        ram_level = wr_ptr_q - rd_ptr_q;
        out_load  = 1'b0;
        ram_rd    = rd_acc;
        if (FWFT != 0) begin
            // Greedy two-stage prefetch: RAM -> mid -> output, refilled whenever a slot frees up.
            out_load = !flush && mid_valid_q && (!rd_valid_q || rd_acc);
            ram_rd   = !flush && (ram_level != '0) && (!mid_valid_q || out_load);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[AWIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_rd && (FWFT != 0)) begin
            mid_data_q <= mem[rd_ptr_q[AWIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mid_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // A fresh error in the same cycle as clr_err keeps the flag set.
            overflow_q  <= ovf_evt || (overflow_q && !clr_err);
            underflow_q <= unf_evt || (underflow_q && !clr_err);
            if (flush) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                mid_valid_q <= 1'b0;
                rd_valid_q  <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr_q <= wr_ptr_q + ONE;
                end
                if (ram_rd) begin
                    rd_ptr_q <= rd_ptr_q + ONE;
                end
                if (wr_acc && !rd_acc) begin
                    count_q <= count_q + ONE;
                end else if (rd_acc && !wr_acc) begin
                    count_q <= count_q - ONE;
                end
                if (FWFT != 0) begin
                    if (ram_rd) begin
                        mid_valid_q <= 1'b1;
                    end else if (out_load) begin
                        mid_valid_q <= 1'b0;
                    end
                    if (out_load) begin
                        rd_data_q  <= mid_data_q;
                        rd_valid_q <= 1'b1;
                    end else if (rd_acc) begin
                        rd_valid_q <= 1'b0;
                    end
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem[rd_ptr_q[AWIDTH-1:0]];
                    end
                end
            end
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_c;
    assign empty        = empty_c;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Bench for sync_fifo_ram: a standard-read and an FWFT instance share one stimulus stream and
// are each compared against a queue-based model after every clock edge.
module tb_sync_fifo_ram;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] s_rd_data, f_rd_data;
    logic [8:0] s_count, f_count;
    logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    always #5 clk = ~clk;

    sync_fifo_ram #(.DWIDTH(8), .AWIDTH(8), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    sync_fifo_ram #(.DWIDTH(8), .AWIDTH(8), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    // Reference model: plain queues. FWFT head is visible once it was written two or more edges ago.
    typedef struct {
        logic [7:0] d;
        int         w;
    } fent_t;

    logic [7:0] sq[$];
    fent_t      fq[$];
    int         edge_n = 0;
    logic [7:0] m_s_data, m_f_data;
    bit         m_s_valid, m_s_ovf, m_s_unf, m_f_ovf, m_f_unf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit f_vis(input int e);
        if (fq.size() == 0) return 1'b0;
        return (fq[0].w + 2 <= e);
    endfunction

    task automatic model_reset();
        sq.delete();
        fq.delete();
        m_s_data  = 8'h00;
        m_f_data  = 8'h00;
        m_s_valid = 1'b0;
        m_s_ovf   = 1'b0;
        m_s_unf   = 1'b0;
        m_f_ovf   = 1'b0;
        m_f_unf   = 1'b0;
    endtask

    task automatic model_edge();
        bit    s_full_p, s_empty_p, f_full_p, f_empty_p;
        fent_t tmp;
        s_full_p  = (sq.size() == DEPTH);
        s_empty_p = (sq.size() == 0);
        f_full_p  = (fq.size() == DEPTH);
        f_empty_p = !f_vis(edge_n);
        edge_n++;
        m_s_ovf = (wr_en && s_full_p && !flush) || (m_s_ovf && !clr_err);
        m_s_unf = (rd_en && s_empty_p && !flush) || (m_s_unf && !clr_err);
        m_f_ovf = (wr_en && f_full_p && !flush) || (m_f_ovf && !clr_err);
        m_f_unf = (rd_en && f_empty_p && !flush) || (m_f_unf && !clr_err);
        m_s_valid = 1'b0;
        if (flush) begin
            sq.delete();
            fq.delete();
        end else begin
            if (rd_en && !s_empty_p) begin
                m_s_data  = sq.pop_front();
                m_s_valid = 1'b1;
            end
            if (wr_en && !s_full_p) sq.push_back(wr_data);
            if (rd_en && !f_empty_p) tmp = fq.pop_front();
            if (wr_en && !f_full_p) begin
                tmp.d = wr_data;
                tmp.w = edge_n;
                fq.push_back(tmp);
            end
        end
        if (f_vis(edge_n)) m_f_data = fq[0].d;
    endtask

    task automatic compare_all();
        int sn, fn;
        bit fv;
        sn = sq.size();
        fn = fq.size();
        fv = f_vis(edge_n);
        chk("std_count", 32'(s_count), 32'(sn));
        chk("std_empty", 32'(s_empty), 32'(sn == 0));
        chk("std_full", 32'(s_full), 32'(sn == DEPTH));
        chk("std_almost_full", 32'(s_af), 32'(sn >= DEPTH - 2));
        chk("std_almost_empty", 32'(s_ae), 32'(sn <= 2));
        chk("std_rd_valid", 32'(s_rd_valid), 32'(m_s_valid));
        chk("std_rd_data", 32'(s_rd_data), 32'(m_s_data));
        chk("std_overflow", 32'(s_ovf), 32'(m_s_ovf));
        chk("std_underflow", 32'(s_unf), 32'(m_s_unf));
        chk("fwft_count", 32'(f_count), 32'(fn));
        chk("fwft_empty", 32'(f_empty), 32'(!fv));
        chk("fwft_full", 32'(f_full), 32'(fn == DEPTH));
        chk("fwft_almost_full", 32'(f_af), 32'(fn >= DEPTH - 2));
        chk("fwft_almost_empty", 32'(f_ae), 32'(fn <= 2));
        chk("fwft_rd_valid", 32'(f_rd_valid), 32'(fv));
        chk("fwft_rd_data", 32'(f_rd_data), 32'(m_f_data));
        chk("fwft_overflow", 32'(f_ovf), 32'(m_f_ovf));
        chk("fwft_underflow", 32'(f_unf), 32'(m_f_unf));
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         rd;
        bit         clr;
        int         cnt;
        bit         sv;
        logic [7:0] sd;
        bit         fv;
        logic [7:0] fd;
        bit         unf;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 8'h13, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0};
        vecs[3]  = '{1'b1, 8'h14, 1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'h11, 1'b1, 8'h12, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h12, 1'b1, 8'h13, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h13, 1'b1, 8'h14, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h14, 1'b0, 8'h14, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h14, 1'b0, 8'h14, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h14, 1'b0, 8'h14, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h14, 1'b0, 8'h14, 1'b0};

        // Basic write/read ordering, read latency, underflow and clr_err.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].wr, vecs[i].d, vecs[i].rd, 1'b0, vecs[i].clr);
            chk("vec_std_count", 32'(s_count), 32'(vecs[i].cnt));
            chk("vec_fwft_count", 32'(f_count), 32'(vecs[i].cnt));
            chk("vec_std_valid", 32'(s_rd_valid), 32'(vecs[i].sv));
            chk("vec_std_data", 32'(s_rd_data), 32'(vecs[i].sd));
            chk("vec_fwft_valid", 32'(f_rd_valid), 32'(vecs[i].fv));
            chk("vec_fwft_data", 32'(f_rd_data), 32'(vecs[i].fd));
            chk("vec_std_underflow", 32'(s_unf), 32'(vecs[i].unf));
            chk("vec_fwft_underflow", 32'(f_unf), 32'(vecs[i].unf));
        end

        // Fill to full; almost_full from 254; overflow even with a concurrent read.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 252) chk("af_low_253", 32'(s_af), 32'd0);
            if (i == 253) chk("af_set_254", 32'(s_af), 32'd1);
        end
        chk("full_256", 32'(s_full), 32'd1);
        chk("count_256", 32'(s_count), 32'd256);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("overflow_set", 32'(s_ovf), 32'd1);
        chk("count_after_drop", 32'(f_count), 32'd256);
        step(1'b1, 8'hEF, 1'b1, 1'b0, 1'b1);
        chk("ovf_new_err_wins", 32'(f_ovf), 32'd1);
        chk("count_wr_rd_full", 32'(s_count), 32'd255);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("overflow_cleared", 32'(s_ovf), 32'd0);

        // Concurrent read/write at count 5 across pointer wrap.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
        chk("steady_std_count", 32'(s_count), 32'd5);
        chk("steady_fwft_count", 32'(f_count), 32'd5);

        // FWFT latency and back-to-back pops without bubbles.
        do_reset();
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("fwft_count_1", 32'(f_count), 32'd1);
        chk("fwft_not_yet", 32'(f_rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("fwft_edge1", 32'(f_rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("fwft_edge2_valid", 32'(f_rd_valid), 32'd1);
        chk("fwft_edge2_data", 32'(f_rd_data), 32'h0A5);
        for (int i = 1; i < 10; i++) step(1'b1, 8'(8'hA5 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (i < 9) begin
                chk("fwft_no_bubble", 32'(f_rd_valid), 32'd1);
                chk("fwft_stream_data", 32'(f_rd_data), 32'(8'hA6 + i));
            end
        end
        chk("fwft_drained", 32'(f_empty), 32'd1);

        // Underflow at empty, then flush with a concurrent write.
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("underflow_std", 32'(s_unf), 32'd1);
        chk("underflow_count", 32'(s_count), 32'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 32'(f_count), 32'd0);
        chk("flush_empty", 32'(f_empty), 32'd1);
        chk("flush_rd_valid", 32'(f_rd_valid), 32'd0);
        chk("flush_keeps_unf", 32'(s_unf), 32'd1);

        // Asynchronous reset mid-burst.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        chk("burst_count_9", 32'(s_count), 32'd9);
        wr_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_count", 32'(f_count), 32'd0);
        wr_en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post_rst_fwft_data", 32'(f_rd_data), 32'h05A);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("post_rst_std_data", 32'(s_rd_data), 32'h05A);

        // Randomized traffic with write-heavy and read-heavy phases.
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 600; i++) begin
                step(($urandom_range(99) < ((ph % 2 == 0) ? 85 : 30)) ? 1'b1 : 1'b0,
                     8'($urandom),
                     ($urandom_range(99) < ((ph % 2 == 0) ? 30 : 85)) ? 1'b1 : 1'b0,
                     ($urandom_range(255) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(31) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
